// File: rtl/hf_tans_recoder.sv
// Bit-serial Huffman (A=0, B=10, C=11, LSB first) to tANS (L=8, fA=4, fB=2, fC=2) transcoder.
// One Huffman bit is consumed per clock. Each decoded symbol is encoded at the following edge.
module hf_tans_recoder #(
    parameter int STREAM_BITS = 11
) (
    input  logic       PHI,
    input  logic       RST,
    input  logic       I_F,
    input  logic       i_stream,
    output logic [1:0] BTR,
    output logic [2:0] o_stream,
    output logic [3:0] final_state
);

    typedef enum logic [1:0] {SYM_A, SYM_B, SYM_C} sym_t;
    typedef enum logic [1:0] {ROOT, ONE, DONE} dec_t;
    typedef struct packed {
        logic vld;
        sym_t sym;
    } pend_t;

    localparam logic [7:0] LAST = 8'(STREAM_BITS);

    dec_t       dec, dec_cur, dec_nxt;
    logic [7:0] cnt, cnt_base, cnt_nxt;
    pend_t      pend, pend_nxt;
    logic [3:0] x;

    // I_F restarts decoding in the same cycle, so its bit is decoded from ROOT as bit 0.
    always_comb begin
        dec_cur  = I_F ? ROOT : dec;
        cnt_base = I_F ? 8'd0 : cnt;
        dec_nxt  = dec_cur;
        cnt_nxt  = cnt_base;
        pend_nxt = '{vld: 1'b0, sym: SYM_A};
        if (dec_cur != DONE) begin
            cnt_nxt = cnt_base + 8'd1;
            if (dec_cur == ROOT) begin
                if (i_stream) begin
                    dec_nxt = ONE;
                end else begin
                    dec_nxt  = ROOT;
                    pend_nxt = '{vld: 1'b1, sym: SYM_A};
                end
            end else begin
                dec_nxt  = ROOT;
                pend_nxt = '{vld: 1'b1, sym: (i_stream ? SYM_C : SYM_B)};
            end
            // A prefix still open at the window end is dropped with the move to DONE.
            if (cnt_nxt == LAST) dec_nxt = DONE;
        end
    end

    logic [1:0] enc_nb;
    logic [2:0] enc_bits;
    logic [3:0] enc_xp, enc_base, enc_f, enc_next;

    // x' = X >> nb, next = 8 + base + (x' - f)
    always_comb begin
        case (pend.sym)
            SYM_B: begin
                enc_nb   = 2'd2;
                enc_bits = {1'b0, x[1:0]};
                enc_xp   = {2'b00, x[3:2]};
                enc_base = 4'd4;
                enc_f    = 4'd2;
            end
            SYM_C: begin
                enc_nb   = 2'd2;
                enc_bits = {1'b0, x[1:0]};
                enc_xp   = {2'b00, x[3:2]};
                enc_base = 4'd6;
                enc_f    = 4'd2;
            end
            default: begin
                enc_nb   = 2'd1;
                enc_bits = {2'b00, x[0]};
                enc_xp   = {1'b0, x[3:1]};
                enc_base = 4'd0;
                enc_f    = 4'd4;
            end
        endcase
        enc_next = 4'd8 + enc_base + enc_xp - enc_f;
    end

    always_ff @(posedge PHI or negedge RST) begin
        if (!RST) begin
            dec      <= ROOT;
            cnt      <= 8'd0;
            pend     <= '{vld: 1'b0, sym: SYM_A};
            x        <= 4'd8;
            BTR      <= 2'd0;
            o_stream <= 3'd0;
        end else begin
            dec  <= dec_nxt;
            cnt  <= cnt_nxt;
            pend <= pend_nxt;
            if (I_F) begin
                x        <= 4'd8;
                BTR      <= 2'd0;
                o_stream <= 3'd0;
            end else if (pend.vld) begin
                x        <= enc_next;
                BTR      <= enc_nb;
                o_stream <= enc_bits;
            end else begin
                BTR      <= 2'd0;
                o_stream <= 3'd0;
            end
        end
    end

    assign final_state = x;

endmodule

// File: tb/tb_hf_tans_recoder.sv
// Directed bench for hf_tans_recoder: reset, single symbol, full message, restart,
// async reset and every (state, symbol) encode step.
module tb_hf_tans_recoder;

    logic       PHI, RST;
    logic       I_F, i_stream;
    logic [1:0] BTR;
    logic [2:0] o_stream;
    logic [3:0] final_state;
    logic       if_1, in_1;
    logic [1:0] btr_1;
    logic [2:0] os_1;
    logic [3:0] fs_1;

    int checks = 0;
    int failures = 0;

    hf_tans_recoder #(.STREAM_BITS(11)) dut (
        .PHI(PHI), .RST(RST), .I_F(I_F), .i_stream(i_stream),
        .BTR(BTR), .o_stream(o_stream), .final_state(final_state)
    );

    hf_tans_recoder #(.STREAM_BITS(1)) dut1 (
        .PHI(PHI), .RST(RST), .I_F(if_1), .i_stream(in_1),
        .BTR(btr_1), .o_stream(os_1), .final_state(fs_1)
    );

    initial PHI = 1'b0;
    always #5 PHI = ~PHI;

    task automatic tick();
        @(posedge PHI);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Message A C B A A A B A: bits 0,1,1,1,0,0,0,0,1,0,0 (bit i at index i)
    logic [10:0] msg = 11'b00100001110;
    int exp_btr[12] = '{1, 0, 2, 0, 2, 1, 1, 1, 0, 2, 1, 0};
    int exp_os[12]  = '{0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0};

    // Prefixes (arrival order, bit 0 first) that drive the state from 8 to 8..15
    logic [3:0] pre_bits[8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0011,
                                4'b0001, 4'b0101, 4'b0011, 4'b1111};
    int pre_len[8] = '{0, 4, 3, 3, 2, 4, 2, 4};
    logic [1:0] sym_bits[3] = '{2'b00, 2'b01, 2'b11};
    int sym_len[3] = '{1, 2, 2};
    int tbl_next[3][8] = '{'{8, 8, 9, 9, 10, 10, 11, 11},
                           '{12, 12, 12, 12, 13, 13, 13, 13},
                           '{14, 14, 14, 14, 15, 15, 15, 15}};
    int tbl_bits[3][8] = '{'{0, 1, 0, 1, 0, 1, 0, 1},
                           '{0, 1, 2, 3, 0, 1, 2, 3},
                           '{0, 1, 2, 3, 0, 1, 2, 3}};
    int tbl_nb[3] = '{1, 2, 2};

    initial begin
        RST = 1'b1; I_F = 1'b0; i_stream = 1'b0; if_1 = 1'b0; in_1 = 1'b0;
        #2 RST = 1'b0;
        tick(); tick();
        chk("rst_btr", BTR, 0);
        chk("rst_os", o_stream, 0);
        chk("rst_fs", final_state, 4'b1000);
        chk("rst_fs1", fs_1, 4'b1000);
        #2 RST = 1'b1;

        // single A on the 1-bit window
        if_1 = 1'b1; in_1 = 1'b0; tick();
        if_1 = 1'b0; tick();
        chk("single_btr_e1", btr_1, 1);
        chk("single_os_e1", os_1, 0);
        chk("single_fs_e1", fs_1, 8);
        tick();
        chk("single_btr_e2", btr_1, 0);
        tick();
        chk("single_btr_e3", btr_1, 0);

        // full message
        I_F = 1'b1; i_stream = msg[0]; tick();
        chk("msg_btr_e0", BTR, 0);
        chk("msg_fs_e0", final_state, 8);
        for (int e = 1; e <= 12; e++) begin
            I_F = 1'b0;
            i_stream = (e <= 10) ? msg[e] : 1'bx;
            tick();
            chk($sformatf("msg_btr_e%0d", e), BTR, exp_btr[e-1]);
            chk($sformatf("msg_os_e%0d", e), o_stream, exp_os[e-1]);
        end
        chk("msg_final", final_state, 4'b1010);
        for (int k = 0; k < 4; k++) begin
            i_stream = 1'bx; tick();
        end
        chk("msg_hold_fs", final_state, 4'b1010);
        chk("msg_hold_btr", BTR, 0);

        // restart at bit 5: the pending B would otherwise emit (2,010)
        I_F = 1'b1; i_stream = msg[0]; tick();
        for (int e = 1; e <= 4; e++) begin
            I_F = 1'b0; i_stream = msg[e]; tick();
        end
        chk("rs_fs_before", final_state, 14);
        I_F = 1'b1; i_stream = 1'b0; tick();
        chk("rs_btr", BTR, 0);
        chk("rs_os", o_stream, 0);
        chk("rs_fs", final_state, 8);
        for (int k = 1; k <= 12; k++) begin
            I_F = 1'b0; i_stream = 1'b0; tick();
            chk($sformatf("rs_btr_e%0d", k), BTR, (k <= 11) ? 1 : 0);
            chk($sformatf("rs_os_e%0d", k), o_stream, 0);
        end

        // asynchronous reset between edges
        I_F = 1'b1; i_stream = msg[0]; tick();
        for (int e = 1; e <= 5; e++) begin
            I_F = 1'b0; i_stream = msg[e]; tick();
        end
        chk("ar_btr_pre", BTR, 2);
        chk("ar_os_pre", o_stream, 2);
        chk("ar_fs_pre", final_state, 13);
        #2 RST = 1'b0;
        #1;
        chk("ar_btr", BTR, 0);
        chk("ar_os", o_stream, 0);
        chk("ar_fs", final_state, 8);
        #2 RST = 1'b1;
        tick();

        // every (state, symbol) step
        for (int s = 0; s < 8; s++) begin
            for (int y = 0; y < 3; y++) begin
                logic [5:0] seq;
                int n;
                seq = 6'(pre_bits[s]) | (6'(sym_bits[y]) << pre_len[s]);
                n = pre_len[s] + sym_len[y];
                for (int i = 0; i < n; i++) begin
                    I_F = (i == 0); i_stream = seq[i]; tick();
                end
                chk($sformatf("ex_pre_s%0d_y%0d", s + 8, y), final_state, s + 8);
                I_F = 1'b0; i_stream = 1'b1; tick();
                chk($sformatf("ex_btr_s%0d_y%0d", s + 8, y), BTR, tbl_nb[y]);
                chk($sformatf("ex_os_s%0d_y%0d", s + 8, y), o_stream, tbl_bits[y][s]);
                chk($sformatf("ex_nx_s%0d_y%0d", s + 8, y), final_state, tbl_next[y][s]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
